fp_norm_seq: RTL and testbench



---
 rtl/fp_norm_seq.sv | 145 ++++++++++++++
 tb/tb_fp_norm_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_seq.sv
// Iterative normalize-and-pack stage for single-precision adder results.
// One normalization step per clock, with valid/ready handshakes on both sides.
module fp_norm_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic        out_ovf,
  output logic        out_zero,
  output logic        out_denorm,
  output logic [4:0]  out_steps
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        ready_q, ready_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [24:0] mant_q, mant_d;
  logic [4:0]  steps_q, steps_d;
  logic [31:0] z_q, z_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;
  logic        denorm_q, denorm_d;
  logic [7:0]  exp_inc;

  assign exp_inc = exp_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    steps_d  = steps_q;
    z_d      = z_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && ready_q) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
          steps_d = 5'd0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        steps_d = (steps_q == 5'd31) ? 5'd31 : steps_q + 5'd1;
        if (exp_q == 8'hFF) begin
          z_d      = {sign_q, 8'hFF, mant_q[22:0]};
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
          denorm_d = 1'b0;
          state_d  = S_DONE;
        end else if (mant_q == 25'd0) begin
          z_d      = 32'd0;
          ovf_d    = 1'b0;
          zero_d   = 1'b1;
          denorm_d = 1'b0;
          state_d  = S_DONE;
        end else if (mant_q[24]) begin
          // Carry-out: shift right (truncate) and bump the exponent.
          mant_d = mant_q >> 1;
          exp_d  = exp_inc;
          if (exp_inc == 8'hFF) begin
            z_d      = {sign_q, 8'hFF, 23'd0};
            ovf_d    = 1'b1;
            zero_d   = 1'b0;
            denorm_d = 1'b0;
            state_d  = S_DONE;
          end
        end else if (mant_q[23]) begin
          z_d      = {sign_q, exp_q, mant_q[22:0]};
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
          denorm_d = 1'b0;
          state_d  = S_DONE;
        end else if (exp_q <= 8'd1) begin
          z_d      = {sign_q, 8'h00, mant_q[22:0]};
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
          denorm_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 8'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so that ready stays low during reset and rises on the first edge after it.
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= 8'd0;
      mant_q   <= 25'd0;
      steps_q  <= 5'd0;
      z_q      <= 32'd0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      steps_q  <= steps_d;
      z_q      <= z_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = (state_q == S_DONE);
  assign out_z      = z_q;
  assign out_ovf    = ovf_q;
  assign out_zero   = zero_q;
  assign out_denorm = denorm_q;
  assign out_steps  = steps_q;

endmodule

// File: tb/tb_fp_norm_seq.sv
// Directed-vector bench for fp_norm_seq: result table plus backpressure and mid-flight reset sequences.
module tb_fp_norm_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'd0;
  logic [24:0] in_mant = 25'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_z;
  logic        out_ovf;
  logic        out_zero;
  logic        out_denorm;
  logic [4:0]  out_steps;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_norm_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .out_denorm (out_denorm),
    .out_steps  (out_steps)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [31:0] z;
    logic        ovf;
    logic        zero;
    logic        denorm;
    int          steps;
    int          edges;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Presents one input, returns at the negedge after the accepting edge.
  task automatic launch(input logic s, input logic [7:0] e, input logic [24:0] m);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edges counted from the accepting edge (inclusive) until out_valid is seen.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int edges);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_z"}, out_z, v.z);
    chk({tag, "_flags"}, {29'd0, out_ovf, out_zero, out_denorm}, {29'd0, v.ovf, v.zero, v.denorm});
    chk({tag, "_steps"}, {27'd0, out_steps}, v.steps[31:0]);
    chk({tag, "_edges"}, edges[31:0], v.edges[31:0]);
    $display("%s: z=0x%08h ovf=%0b zero=%0b den=%0b steps=%0d edges=%0d",
             tag, out_z, out_ovf, out_zero, out_denorm, out_steps, edges);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_fall"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  vec_t vecs[8];
  vec_t v;
  int   edges;
  logic [31:0] held_z;

  initial begin
    vecs[0] = '{1'b0, 8'd127, 25'h0C00000, 32'h3FC00000, 1'b0, 1'b0, 1'b0, 1, 2};
    vecs[1] = '{1'b0, 8'd127, 25'h1800000, 32'h40400000, 1'b0, 1'b0, 1'b0, 2, 3};
    vecs[2] = '{1'b0, 8'd130, 25'h0200000, 32'h40000000, 1'b0, 1'b0, 1'b0, 3, 4};
    vecs[3] = '{1'b0, 8'd127, 25'h0000001, 32'h34000000, 1'b0, 1'b0, 1'b0, 24, 25};
    vecs[4] = '{1'b1, 8'd100, 25'h0000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1, 2};
    vecs[5] = '{1'b0, 8'd254, 25'h1000000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1, 2};
    vecs[6] = '{1'b1, 8'd255, 25'h0400001, 32'hFFC00001, 1'b0, 1'b0, 1'b0, 1, 2};
    vecs[7] = '{1'b1, 8'd0,   25'h0000005, 32'h80000005, 1'b0, 1'b0, 1'b1, 1, 2};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outs", out_z | {27'd0, out_steps}, 32'd0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      launch(v.sign, v.exp, v.mant);
      wait_done(edges);
      check_result($sformatf("vec%0d", i), v, edges);
      release_result($sformatf("vec%0d", i));
    end

    // Subnormal held under backpressure, with in_valid asserted and ignored.
    v = '{1'b0, 8'd3, 25'h0100000, 32'h00400000, 1'b0, 1'b0, 1'b1, 3, 4};
    launch(v.sign, v.exp, v.mant);
    in_valid = 1'b1;
    in_exp   = 8'd127;
    in_mant  = 25'h0C00000;
    wait_done(edges);
    check_result("subn", v, edges);
    held_z = out_z;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold%0d_z", c), out_z, held_z);
      chk($sformatf("hold%0d_valid_ready", c), {30'd0, out_valid, in_ready}, 32'd2);
    end
    in_valid = 1'b0;
    release_result("subn");

    // Reset in the middle of a long normalization.
    launch(1'b0, 8'd127, 25'h0000001);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", out_z | {27'd0, out_steps}, 32'd0);
    chk("midrst_valid_ready", {30'd0, out_valid, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready_back", {31'd0, in_ready}, 32'd1);
    edges = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) edges++;
    end
    chk("midrst_no_valid", edges[31:0], 32'd0);
    $display("midrst: no result after reset, in_ready=%0b", in_ready);
    v = vecs[1];
    launch(v.sign, v.exp, v.mant);
    wait_done(edges);
    check_result("postrst", v, edges);
    release_result("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
